// File: rtl/pwm_sequencer.sv
// pwm_sequencer
// Steps a photonic-switch PWM generator through a small programmable table.
// Each entry holds an A (reset-side) count, a B (set-side) count and a dwell
// (d means d+1 frames). Entries advance only on frame boundaries, so the
// generator always sees a complete frame with stable counts.
//
// Ports
//   clkCore            : single clock, all flops update on its rising edge
//   reset              : synchronous, active-low
//   cfg_we/cfg_addr    : table write strobe and address
//   cfg_a/cfg_b/cfg_dwell : entry contents written when cfg_we=1
//   period             : frame length minus 1 (captured at start)
//   last_idx           : index of the final entry (captured, clamped to DEPTH-1)
//   loop               : 1 = wrap to entry 0 after last_idx, 0 = one-shot
//   start/stop         : single-cycle control pulses
//   A_val/B_val        : counts presented to the generator
//   en/load            : generator enable and frame-reload strobe
//   busy/done/cur_idx  : status
module pwm_sequencer #(
  parameter int W        = 7,
  parameter int DEPTH    = 8,
  parameter int DWELL_W  = 8,
  parameter int PERIOD_W = 8,
  localparam int IW      = $clog2(DEPTH)
) (
  input  logic                clkCore,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [IW-1:0]       cfg_addr,
  input  logic [W-1:0]        cfg_a,
  input  logic [W-1:0]        cfg_b,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  input  logic [PERIOD_W-1:0] period,
  input  logic [IW-1:0]       last_idx,
  input  logic                loop,
  input  logic                start,
  input  logic                stop,
  output logic [W-1:0]        A_val,
  output logic [W-1:0]        B_val,
  output logic                en,
  output logic                load,
  output logic                busy,
  output logic                done,
  output logic [IW-1:0]       cur_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Table storage, deliberately not reset
  logic [W-1:0]       a_mem_q [DEPTH];
  logic [W-1:0]       b_mem_q [DEPTH];
  logic [DWELL_W-1:0] d_mem_q [DEPTH];

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] frame_q, frame_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       last_q, last_d;
  logic                loop_q, loop_d;
  logic                stop_pend_q, stop_pend_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic                en_q, en_d;
  logic                load_q, load_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [IW-1:0]       last_clamped_s;
  logic [IW-1:0]       idx_inc_s;
  logic                stop_now_s;

  // Clamp is only needed when DEPTH leaves unused index codes
  if (DEPTH < (1 << IW)) begin : g_clamp
    assign last_clamped_s = (last_idx > IW'(DEPTH - 1)) ? IW'(DEPTH - 1) : last_idx;
  end else begin : g_noclamp
    assign last_clamped_s = last_idx;
  end

  assign idx_inc_s = idx_q + {{(IW-1){1'b0}}, 1'b1};

  // Table write port; a fetch in the same cycle still sees the old entry
  always_ff @(posedge clkCore) begin
    if (cfg_we) begin
      a_mem_q[cfg_addr] <= cfg_a;
      b_mem_q[cfg_addr] <= cfg_b;
      d_mem_q[cfg_addr] <= cfg_dwell;
    end
  end

  // Sequencer next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    period_d    = period_q;
    dwell_d     = dwell_q;
    idx_d       = idx_q;
    last_d      = last_q;
    loop_d      = loop_q;
    stop_pend_d = stop_pend_q;
    a_d         = a_q;
    b_d         = b_q;
    done_d      = done_q;
    en_d        = 1'b0;
    busy_d      = 1'b0;
    load_d      = 1'b0;
    // A stop arriving on the last frame cycle is honoured at that boundary
    stop_now_s  = stop_pend_q | stop;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          state_d     = ST_RUN;
          period_d    = period;
          last_d      = last_clamped_s;
          loop_d      = loop;
          frame_d     = {PERIOD_W{1'b0}};
          idx_d       = {IW{1'b0}};
          done_d      = 1'b0;
          stop_pend_d = 1'b0;
          a_d         = a_mem_q[{IW{1'b0}}];
          b_d         = b_mem_q[{IW{1'b0}}];
          dwell_d     = d_mem_q[{IW{1'b0}}];
        end else begin
          stop_pend_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (frame_q == period_q) begin
          frame_d     = {PERIOD_W{1'b0}};
          stop_pend_d = 1'b0;
          if (stop_now_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
          end else if (dwell_q != {DWELL_W{1'b0}}) begin
            dwell_d = dwell_q - {{(DWELL_W-1){1'b0}}, 1'b1};
          end else if (idx_q < last_q) begin
            idx_d   = idx_inc_s;
            a_d     = a_mem_q[idx_inc_s];
            b_d     = b_mem_q[idx_inc_s];
            dwell_d = d_mem_q[idx_inc_s];
          end else if (loop_q) begin
            idx_d   = {IW{1'b0}};
            a_d     = a_mem_q[{IW{1'b0}}];
            b_d     = b_mem_q[{IW{1'b0}}];
            dwell_d = d_mem_q[{IW{1'b0}}];
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          frame_d     = frame_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
          stop_pend_d = stop_now_s;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        stop_pend_d = 1'b0;
        done_d      = 1'b0;
      end
    endcase

    // Outputs are registered from the next state so they align with it
    en_d   = (state_d == ST_RUN);
    busy_d = (state_d == ST_RUN);
    load_d = (state_d == ST_RUN) && (frame_d == {PERIOD_W{1'b0}});
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clkCore) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      frame_q     <= {PERIOD_W{1'b0}};
      period_q    <= {PERIOD_W{1'b0}};
      dwell_q     <= {DWELL_W{1'b0}};
      idx_q       <= {IW{1'b0}};
      last_q      <= {IW{1'b0}};
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      en_q        <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      period_q    <= period_d;
      dwell_q     <= dwell_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      loop_q      <= loop_d;
      stop_pend_q <= stop_pend_d;
      a_q         <= a_d;
      b_q         <= b_d;
      en_q        <= en_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign A_val   = a_q;
  assign B_val   = b_q;
  assign en      = en_q;
  assign load    = load_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cur_idx = idx_q;

endmodule
